pxs_vga_timing_gen: RTL and testbench



---
 rtl/pxs_vga_timing_gen.sv | 93 +++++++++
 tb/tb_pxs_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pxs_vga_timing_gen.sv
// VGA timing source: free-running h/v counters drive a registered 23-bit pixel stream
// {HS, VS, XC, YC, Active} plus a start-of-frame pulse.
module pxs_vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        px_en,
    output logic [22:0] VGAStr_o,
    output logic        frame_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("pxs_vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // 11-bit bounds so a total of exactly 1024 still compares correctly.
    localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
    localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
    localparam logic [22:0] StrReset  = {~SYNC_POL, ~SYNC_POL, 21'd0};

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [22:0] str_q, str_d;
    logic        frame_q, frame_d;

    logic [10:0] h_ext, v_ext;
    logic        hs, vs, active;

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    always_comb begin
        hs      = ~SYNC_POL;
        vs      = ~SYNC_POL;
        active  = 1'b0;
        h_d     = h_q;
        v_d     = v_q;

        if (h_ext >= HSyncBeg && h_ext < HSyncEnd) begin
            hs = SYNC_POL;
        end
        if (v_ext >= VSyncBeg && v_ext < VSyncEnd) begin
            vs = SYNC_POL;
        end
        active  = (h_ext < HActEnd) && (v_ext < VActEnd);

        str_d   = {hs, vs, h_q, v_q, active};
        frame_d = (h_q == 10'd0) && (v_q == 10'd0);

        if (h_q == HLast) begin
            h_d = 10'd0;
            v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            str_q   <= StrReset;
            frame_q <= 1'b0;
        end else if (px_en) begin
            h_q     <= h_d;
            v_q     <= v_d;
            str_q   <= str_d;
            frame_q <= frame_d;
        end
    end

    assign VGAStr_o = str_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_pxs_vga_timing_gen.sv
// Bench for pxs_vga_timing_gen: three parameterisations checked every cycle against an
// index-based timing model, plus directed literal checks of line, frame, stall and reset.
module tb_pxs_vga_timing_gen;

    logic        px_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        px_en  = 1'b0;
    logic [22:0] str_d, str_s, str_m;
    logic        frm_d, frm_s, frm_m;

    int total = 0;
    int bad   = 0;

    always #5 px_clk = ~px_clk;

    pxs_vga_timing_gen dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .px_en    (px_en),
        .VGAStr_o (str_d),
        .frame_o  (frm_d)
    );

    pxs_vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .px_clk   (px_clk),
        .reset    (reset),
        .px_en    (px_en),
        .VGAStr_o (str_s),
        .frame_o  (frm_s)
    );

    pxs_vga_timing_gen #(
        .H_ACTIVE (20), .H_FP (4), .H_SYNC (6), .H_BP (2),
        .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b0)
    ) dut_m (
        .px_clk   (px_clk),
        .reset    (reset),
        .px_en    (px_en),
        .VGAStr_o (str_m),
        .frame_o  (frm_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {frame, HS, VS, XC, YC, Active} for the n-th enabled word since reset.
    function automatic logic [23:0] model(input int n, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf,
                                          input int vs, input int vb, input logic pol);
        int ht, vt, p, h, v;
        logic hs_o, vs_o, act;
        if (n < 0) return {1'b0, ~pol, ~pol, 21'd0};
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        p    = n % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        hs_o = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vs_o = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        act  = (h < ha) && (v < va);
        return {p == 0, hs_o, vs_o, 10'(h), 10'(v), act};
    endfunction

    int n_words = -1;
    always @(posedge px_clk or posedge reset) begin
        if (reset) n_words <= -1;
        else if (px_en) n_words <= n_words + 1;
    end

    always @(negedge px_clk) begin
        chk("stream_default", {8'd0, frm_d, str_d},
            {8'd0, model(n_words, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
        chk("stream_small", {8'd0, frm_s, str_s},
            {8'd0, model(n_words, 8, 2, 3, 3, 4, 1, 1, 1, 1'b1)});
        chk("stream_medium", {8'd0, frm_m, str_m},
            {8'd0, model(n_words, 20, 4, 6, 2, 10, 2, 2, 3, 1'b0)});
    end

    function automatic int xc(input logic [22:0] w); return int'(w[20:11]); endfunction
    function automatic int yc(input logic [22:0] w); return int'(w[10:1]); endfunction

    task automatic pulse_reset();
        @(posedge px_clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_now_default", {8'd0, frm_d, str_d}, 32'h0060_0000);
        chk("rst_now_small", {8'd0, frm_s, str_s}, 32'h0000_0000);
        chk("rst_now_medium", {8'd0, frm_m, str_m}, 32'h0060_0000);
        @(negedge px_clk);
        reset = 1'b0;
        @(negedge px_clk);
        chk("restart_default", {8'd0, frm_d, str_d}, 32'h00E0_0001);
        chk("restart_medium", {8'd0, frm_m, str_m}, 32'h00E0_0001);
    endtask

    initial begin
        int d_act, d_hs_lo, d_hs_first, d_hs_last, d_frames;
        int s_hs_hi, s_vs_hi, s_act, s_frames, s_last_frame;
        int m_vs_lo, m_act, m_hs_lo, m_frames, m_last_frame;
        bit found;

        d_act = 0; d_hs_lo = 0; d_hs_first = -1; d_hs_last = -1; d_frames = 0;
        s_hs_hi = 0; s_vs_hi = 0; s_act = 0; s_frames = 0; s_last_frame = -1;
        m_vs_lo = 0; m_act = 0; m_hs_lo = 0; m_frames = 0; m_last_frame = -1;

        repeat (2) @(negedge px_clk);
        chk("reset_default", {8'd0, frm_d, str_d}, 32'h0060_0000);
        chk("reset_small", {8'd0, frm_s, str_s}, 32'h0000_0000);
        reset = 1'b0;
        px_en = 1'b1;

        for (int i = 0; i < 800; i++) begin
            @(negedge px_clk);
            if (i == 0) begin
                chk("first_default", {8'd0, frm_d, str_d}, 32'h00E0_0001);
                chk("first_small", {8'd0, frm_s, str_s}, 32'h0080_0001);
            end
            if (xc(str_d) != i || yc(str_d) != 0) chk("line_xy", xc(str_d), i);
            if (str_d[0]) d_act++;
            if (!str_d[22]) begin
                d_hs_lo++;
                if (d_hs_first < 0) d_hs_first = xc(str_d);
                d_hs_last = xc(str_d);
            end
            if (frm_d) d_frames++;
            if (i < 112) begin
                if (str_s[22]) s_hs_hi++;
                if (str_s[21]) s_vs_hi++;
                if (str_s[0]) s_act++;
            end
            if (frm_s) begin s_frames++; s_last_frame = i; end
            if (i < 544) begin
                if (!str_m[21]) m_vs_lo++;
                if (!str_m[22]) m_hs_lo++;
                if (str_m[0]) m_act++;
            end
            if (frm_m) begin m_frames++; m_last_frame = i; end
        end
        chk("line_active_cnt", d_act, 640);
        chk("line_hs_lo_cnt", d_hs_lo, 96);
        chk("line_hs_first", d_hs_first, 656);
        chk("line_hs_last", d_hs_last, 751);
        chk("line_frames", d_frames, 1);
        chk("small_hs_hi", s_hs_hi, 21);
        chk("small_vs_hi", s_vs_hi, 16);
        chk("small_active", s_act, 32);
        chk("small_frames", s_frames, 8);
        chk("small_last_frame", s_last_frame, 784);
        chk("med_vs_lo", m_vs_lo, 64);
        chk("med_hs_lo", m_hs_lo, 102);
        chk("med_active", m_act, 200);
        chk("med_frames", m_frames, 2);
        chk("med_last_frame", m_last_frame, 544);

        @(negedge px_clk);
        chk("line_next_word", {8'd0, frm_d, str_d}, 32'h0060_0003);

        // Enable stall at XC=100.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge px_clk);
            if (xc(str_d) == 100) found = 1'b1;
        end
        chk("stall_reach", {31'd0, found}, 32'd1);
        px_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge px_clk);
            chk("stall_hold_xc", xc(str_d), 100);
        end
        px_en = 1'b1;
        @(negedge px_clk);
        chk("stall_resume_xc", xc(str_d), 101);

        // Hold frame_o high across a stall on the small instance.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge px_clk);
            if (frm_s) found = 1'b1;
        end
        chk("frame_reach", {31'd0, found}, 32'd1);
        px_en = 1'b0;
        repeat (3) @(negedge px_clk);
        chk("frame_held", {31'd0, frm_s}, 32'd1);
        px_en = 1'b1;
        @(negedge px_clk);
        chk("frame_drop", {31'd0, frm_s}, 32'd0);

        // Reset during default HS.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge px_clk);
            if (xc(str_d) == 700) found = 1'b1;
        end
        chk("hs_reach", {31'd0, found}, 32'd1);
        chk("hs_asserted", {31'd0, str_d[22]}, 32'd0);
        pulse_reset();

        // Reset during medium VS.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge px_clk);
            if (yc(str_m) == 13 && xc(str_m) == 26) found = 1'b1;
        end
        chk("vs_reach", {31'd0, found}, 32'd1);
        chk("vs_asserted", {30'd0, str_m[22:21]}, 32'd0);
        pulse_reset();

        repeat (20) @(negedge px_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
